// File: rtl/newspaper_pkg.sv
// Shared types and constants for the newspaper dispatch controller.
package newspaper_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FAULT = 2'd2
   } state_e;

   localparam logic COIN_5  = 1'b0;
   localparam logic COIN_10 = 1'b1;

   localparam int unsigned UNIT_W = 3;

endpackage

// File: rtl/newspaper_rr_arb.sv
// Round-robin arbiter: picks the first requester after last_i, wrapping around.
module newspaper_rr_arb #(
   parameter int unsigned STATIONS = 2
) (
   input  logic [STATIONS-1:0] req_i,
   input  logic [1:0]          last_i,
   output logic [STATIONS-1:0] grant_o,
   output logic [1:0]          idx_o
);

   // First pass covers stations above last_i, second pass wraps to the rest.
   always_comb begin
      logic found;
      found   = 1'b0;
      grant_o = '0;
      idx_o   = '0;
      for (int unsigned j = 0; j < STATIONS; j++) begin
         if (!found && req_i[j] && (j > 32'(last_i))) begin
            found      = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = 2'(j);
         end
      end
      for (int unsigned j = 0; j < STATIONS; j++) begin
         if (!found && req_i[j] && (j <= 32'(last_i))) begin
            found      = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = 2'(j);
         end
      end
   end

endmodule

// File: rtl/newspaper_dispatch.sv
// Multi-station coin controller sharing one newspaper dispenser over req/ack,
// with stock tracking, change/refund payout and dispenser timeout detection.
module newspaper_dispatch
   import newspaper_pkg::*;
#(
   parameter int unsigned STATIONS = 2,
   parameter int unsigned PRICE    = 3,
   parameter int unsigned STOCK_W  = 6,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [STATIONS-1:0]        coin_valid,
   input  logic [STATIONS-1:0]        coin,
   output logic [STATIONS-1:0]        coin_return,
   output logic [STATIONS-1:0]        newspaper,
   output logic [STATIONS-1:0]        change_valid,
   output logic [UNIT_W*STATIONS-1:0] change_units,
   output logic                       disp_req,
   output logic [1:0]                 disp_id,
   input  logic                       disp_ack,
   input  logic                       stock_load,
   input  logic [STOCK_W-1:0]         stock_value,
   output logic [STOCK_W-1:0]         stock,
   output logic                       sold_out,
   output logic                       fault,
   input  logic                       fault_clr
);

   localparam int unsigned       TW      = $clog2(TIMEOUT + 1);
   localparam logic [UNIT_W-1:0] PRICE_U = UNIT_W'(PRICE);

   state_e                     state_q, state_d;
   logic [STOCK_W-1:0]         stock_q, stock_d;
   logic [1:0]                 last_q, last_d;
   logic [1:0]                 disp_id_q, disp_id_d;
   logic [TW-1:0]              timer_q, timer_d;
   logic [STATIONS-1:0]        newspaper_q, newspaper_d;
   logic [STATIONS-1:0]        change_valid_q, change_valid_d;
   logic [UNIT_W*STATIONS-1:0] change_units_q, change_units_d;

   logic [UNIT_W*STATIONS-1:0] credit_all;
   logic [STATIONS-1:0]        pending;
   logic [STATIONS-1:0]        clr;
   logic [STATIONS-1:0]        arb_grant;
   logic [1:0]                 arb_idx;
   logic                       arb_valid;

   assign sold_out = (stock_q == '0);

   for (genvar i = 0; i < STATIONS; i++) begin : g_st
      logic [UNIT_W-1:0] credit_q, credit_d, add;
      logic              pend_q, pend_d, ret_q, ret_d, accept;

      always_comb begin
         accept   = coin_valid[i] && !pend_q && !sold_out && (state_q != FAULT);
         add      = UNIT_W'(1);
         unique case (coin[i])
            COIN_5:  add = UNIT_W'(1);
            COIN_10: add = UNIT_W'(2);
            default: add = UNIT_W'(1);
         endcase
         credit_d = credit_q;
         pend_d   = pend_q;
         ret_d    = coin_valid[i] && !accept;
         // clr only ever targets a pending station, which cannot accept a coin
         if (clr[i]) begin
            credit_d = '0;
            pend_d   = 1'b0;
         end else if (accept) begin
            credit_d = credit_q + add;
            pend_d   = (credit_d >= PRICE_U);
         end
      end

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            credit_q <= '0;
            pend_q   <= 1'b0;
            ret_q    <= 1'b0;
         end else begin
            credit_q <= credit_d;
            pend_q   <= pend_d;
            ret_q    <= ret_d;
         end
      end

      assign credit_all[UNIT_W*i +: UNIT_W] = credit_q;
      assign pending[i]                     = pend_q;
      assign coin_return[i]                 = ret_q;
   end

   newspaper_rr_arb #(
      .STATIONS (STATIONS)
   ) u_arb (
      .req_i   (pending),
      .last_i  (last_q),
      .grant_o (arb_grant),
      .idx_o   (arb_idx)
   );

   assign arb_valid = |arb_grant;

   always_comb begin
      logic found;
      found          = 1'b0;
      state_d        = state_q;
      stock_d        = stock_q;
      last_d         = last_q;
      disp_id_d      = disp_id_q;
      timer_d        = timer_q;
      clr            = '0;
      newspaper_d    = '0;
      change_valid_d = '0;
      change_units_d = '0;
      unique case (state_q)
         IDLE: begin
            if (stock_load) stock_d = stock_value;
            if (!sold_out && arb_valid) begin
               state_d   = WAIT;
               disp_id_d = arb_idx;
               timer_d   = '0;
            end else if (sold_out) begin
               // Refund the lowest-index pending station, one per cycle.
               for (int unsigned j = 0; j < STATIONS; j++) begin
                  if (!found && pending[j]) begin
                     found             = 1'b1;
                     clr[j]            = 1'b1;
                     change_valid_d[j] = 1'b1;
                     change_units_d[UNIT_W*j +: UNIT_W] = credit_all[UNIT_W*j +: UNIT_W];
                  end
               end
            end
         end
         WAIT: begin
            if (disp_ack) begin
               state_d = IDLE;
               stock_d = stock_q - STOCK_W'(1);
               last_d  = disp_id_q;
               for (int unsigned j = 0; j < STATIONS; j++) begin
                  if (32'(disp_id_q) == j) begin
                     clr[j]         = 1'b1;
                     newspaper_d[j] = 1'b1;
                     if (credit_all[UNIT_W*j +: UNIT_W] > PRICE_U) begin
                        change_valid_d[j] = 1'b1;
                        change_units_d[UNIT_W*j +: UNIT_W] =
                           credit_all[UNIT_W*j +: UNIT_W] - PRICE_U;
                     end
                  end
               end
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               state_d = FAULT;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         FAULT: begin
            if (fault_clr) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q        <= IDLE;
         stock_q        <= '0;
         last_q         <= '0;
         disp_id_q      <= '0;
         timer_q        <= '0;
         newspaper_q    <= '0;
         change_valid_q <= '0;
         change_units_q <= '0;
      end else begin
         state_q        <= state_d;
         stock_q        <= stock_d;
         last_q         <= last_d;
         disp_id_q      <= disp_id_d;
         timer_q        <= timer_d;
         newspaper_q    <= newspaper_d;
         change_valid_q <= change_valid_d;
         change_units_q <= change_units_d;
      end
   end

   assign disp_req     = (state_q == WAIT);
   assign disp_id      = disp_req ? disp_id_q : 2'd0;
   assign fault        = (state_q == FAULT);
   assign stock        = stock_q;
   assign newspaper    = newspaper_q;
   assign change_valid = change_valid_q;
   assign change_units = change_units_q;

endmodule

// File: tb/tb_newspaper_dispatch.sv
// Directed vector bench for newspaper_dispatch (2 stations, price 3 units).
module tb_newspaper_dispatch;

   logic       clk = 1'b0;
   logic       rstn;
   logic [1:0] coin_valid, coin;
   logic [1:0] coin_return, newspaper, change_valid;
   logic [5:0] change_units;
   logic       disp_req;
   logic [1:0] disp_id;
   logic       disp_ack, stock_load;
   logic [5:0] stock_value, stock;
   logic       sold_out, fault, fault_clr;

   int checks = 0;
   int errors = 0;

   newspaper_dispatch #(
      .STATIONS (2),
      .PRICE    (3),
      .STOCK_W  (6),
      .TIMEOUT  (15)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .coin_valid   (coin_valid),
      .coin         (coin),
      .coin_return  (coin_return),
      .newspaper    (newspaper),
      .change_valid (change_valid),
      .change_units (change_units),
      .disp_req     (disp_req),
      .disp_id      (disp_id),
      .disp_ack     (disp_ack),
      .stock_load   (stock_load),
      .stock_value  (stock_value),
      .stock        (stock),
      .sold_out     (sold_out),
      .fault        (fault),
      .fault_clr    (fault_clr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] cv;
      logic [1:0] c;
      logic       ack;
      logic       ld;
      logic [5:0] lv;
      logic       fclr;
      logic [1:0] ret;
      logic [1:0] news;
      logic [1:0] chv;
      logic [5:0] chu;
      logic       req;
      logic [1:0] id;
      logic [5:0] stk;
      logic       sold;
      logic       flt;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic [1:0] cv, c, input logic ack, ld,
                               input logic [5:0] lv, input logic fclr,
                               input logic [1:0] ret, news, chv, input logic [5:0] chu,
                               input logic req, input logic [1:0] id,
                               input logic [5:0] stk, input logic sold, flt);
      vec_t v;
      v.cv = cv;   v.c = c;       v.ack = ack; v.ld = ld;   v.lv = lv; v.fclr = fclr;
      v.ret = ret; v.news = news; v.chv = chv; v.chu = chu; v.req = req;
      v.id = id;   v.stk = stk;   v.sold = sold; v.flt = flt;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input int tag, input logic [31:0] got, exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", nm, tag, got, exp);
      end
   endtask

   task automatic drive(input logic [1:0] cv, c, input logic ack, ld,
                        input logic [5:0] lv, input logic fclr);
      @(negedge clk);
      coin_valid  = cv;
      coin        = c;
      disp_ack    = ack;
      stock_load  = ld;
      stock_value = lv;
      fault_clr   = fclr;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input int tag, input logic [1:0] ret, news, chv,
                             input logic [5:0] chu, input logic req, input logic [1:0] id,
                             input logic [5:0] stk, input logic sold, flt);
      chk("coin_return",  tag, 32'(coin_return),  32'(ret));
      chk("newspaper",    tag, 32'(newspaper),    32'(news));
      chk("change_valid", tag, 32'(change_valid), 32'(chv));
      if (chv != 2'b00) chk("change_units", tag, 32'(change_units), 32'(chu));
      chk("disp_req",     tag, 32'(disp_req),     32'(req));
      if (req) chk("disp_id", tag, 32'(disp_id), 32'(id));
      chk("stock",        tag, 32'(stock),        32'(stk));
      chk("sold_out",     tag, 32'(sold_out),     32'(sold));
      chk("fault",        tag, 32'(fault),        32'(flt));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      coin_valid = '0; coin = '0; disp_ack = 1'b0;
      stock_load = 1'b0; stock_value = '0; fault_clr = 1'b0;

      //   cv     c     ack   ld    lv  fclr   ret    news   chv    chu req id    stk sold flt
      // single paper, exact price on station 0
      add(2'b00,2'b00,1'b0,1'b1,6'd5,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b0,2'd0,6'd5,1'b0,1'b0);
      add(2'b01,2'b01,1'b0,1'b0,6'd0,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b0,2'd0,6'd5,1'b0,1'b0);
      add(2'b01,2'b00,1'b0,1'b0,6'd0,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b0,2'd0,6'd5,1'b0,1'b0);
      add(2'b00,2'b00,1'b0,1'b0,6'd0,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b1,2'd0,6'd5,1'b0,1'b0);
      add(2'b00,2'b00,1'b1,1'b0,6'd0,1'b0, 2'b00,2'b01,2'b00,6'd0, 1'b0,2'd0,6'd4,1'b0,1'b0);
      add(2'b00,2'b00,1'b0,1'b0,6'd0,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b0,2'd0,6'd4,1'b0,1'b0);
      // round-robin: both pending with last_grant 0 -> order 1 then 0
      add(2'b11,2'b11,1'b0,1'b0,6'd0,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b0,2'd0,6'd4,1'b0,1'b0);
      add(2'b11,2'b00,1'b0,1'b0,6'd0,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b0,2'd0,6'd4,1'b0,1'b0);
      add(2'b00,2'b00,1'b0,1'b0,6'd0,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b1,2'd1,6'd4,1'b0,1'b0);
      add(2'b00,2'b00,1'b1,1'b0,6'd0,1'b0, 2'b00,2'b10,2'b00,6'd0, 1'b0,2'd0,6'd3,1'b0,1'b0);
      add(2'b00,2'b00,1'b0,1'b0,6'd0,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b1,2'd0,6'd3,1'b0,1'b0);
      add(2'b00,2'b00,1'b1,1'b0,6'd0,1'b0, 2'b00,2'b01,2'b00,6'd0, 1'b0,2'd0,6'd2,1'b0,1'b0);
      // overpay on station 1, reject while pending and in the ack cycle
      add(2'b10,2'b10,1'b0,1'b0,6'd0,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b0,2'd0,6'd2,1'b0,1'b0);
      add(2'b10,2'b10,1'b0,1'b0,6'd0,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b0,2'd0,6'd2,1'b0,1'b0);
      add(2'b10,2'b00,1'b0,1'b0,6'd0,1'b0, 2'b10,2'b00,2'b00,6'd0, 1'b1,2'd1,6'd2,1'b0,1'b0);
      add(2'b10,2'b00,1'b1,1'b0,6'd0,1'b0, 2'b10,2'b10,2'b10,6'd8, 1'b0,2'd0,6'd1,1'b0,1'b0);
      add(2'b00,2'b00,1'b0,1'b0,6'd0,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b0,2'd0,6'd1,1'b0,1'b0);
      // sold out with a pending loser: refund full credit, then reject coins
      add(2'b11,2'b11,1'b0,1'b0,6'd0,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b0,2'd0,6'd1,1'b0,1'b0);
      add(2'b11,2'b00,1'b0,1'b0,6'd0,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b0,2'd0,6'd1,1'b0,1'b0);
      add(2'b00,2'b00,1'b0,1'b0,6'd0,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b1,2'd0,6'd1,1'b0,1'b0);
      add(2'b00,2'b00,1'b1,1'b0,6'd0,1'b0, 2'b00,2'b01,2'b00,6'd0, 1'b0,2'd0,6'd0,1'b1,1'b0);
      add(2'b00,2'b00,1'b0,1'b0,6'd0,1'b0, 2'b00,2'b00,2'b10,6'd24,1'b0,2'd0,6'd0,1'b1,1'b0);
      add(2'b01,2'b00,1'b0,1'b0,6'd0,1'b0, 2'b01,2'b00,2'b00,6'd0, 1'b0,2'd0,6'd0,1'b1,1'b0);
      add(2'b00,2'b00,1'b0,1'b0,6'd0,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b0,2'd0,6'd0,1'b1,1'b0);
      // timeout setup: reload stock, station 0 pays 4 units and is granted
      add(2'b00,2'b00,1'b0,1'b1,6'd3,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b0,2'd0,6'd3,1'b0,1'b0);
      add(2'b01,2'b01,1'b0,1'b0,6'd0,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b0,2'd0,6'd3,1'b0,1'b0);
      add(2'b01,2'b01,1'b0,1'b0,6'd0,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b0,2'd0,6'd3,1'b0,1'b0);
      add(2'b00,2'b00,1'b0,1'b0,6'd0,1'b0, 2'b00,2'b00,2'b00,6'd0, 1'b1,2'd0,6'd3,1'b0,1'b0);

      #1;
      expect_out(0, 2'b00, 2'b00, 2'b00, 6'd0, 1'b0, 2'd0, 6'd0, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      expect_out(1, 2'b00, 2'b00, 2'b00, 6'd0, 1'b0, 2'd0, 6'd0, 1'b1, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].cv, vecs[i].c, vecs[i].ack, vecs[i].ld, vecs[i].lv, vecs[i].fclr);
         expect_out(100 + i, vecs[i].ret, vecs[i].news, vecs[i].chv, vecs[i].chu,
                    vecs[i].req, vecs[i].id, vecs[i].stk, vecs[i].sold, vecs[i].flt);
      end

      // 14 more WAIT cycles without ack; a load during WAIT is ignored
      for (int k = 0; k < 14; k++) begin
         drive(2'b00, 2'b00, 1'b0, (k == 0), 6'd9, 1'b0);
         expect_out(200 + k, 2'b00, 2'b00, 2'b00, 6'd0, 1'b1, 2'd0, 6'd3, 1'b0, 1'b0);
      end
      drive(2'b00, 2'b00, 1'b0, 1'b0, 6'd0, 1'b0);
      expect_out(300, 2'b00, 2'b00, 2'b00, 6'd0, 1'b0, 2'd0, 6'd3, 1'b0, 1'b1);
      // in FAULT: coin rejected, stray ack and stock load ignored
      drive(2'b10, 2'b00, 1'b1, 1'b1, 6'd9, 1'b0);
      expect_out(301, 2'b10, 2'b00, 2'b00, 6'd0, 1'b0, 2'd0, 6'd3, 1'b0, 1'b1);
      drive(2'b00, 2'b00, 1'b0, 1'b0, 6'd0, 1'b1);
      expect_out(302, 2'b00, 2'b00, 2'b00, 6'd0, 1'b0, 2'd0, 6'd3, 1'b0, 1'b0);
      drive(2'b00, 2'b00, 1'b0, 1'b0, 6'd0, 1'b0);
      expect_out(303, 2'b00, 2'b00, 2'b00, 6'd0, 1'b1, 2'd0, 6'd3, 1'b0, 1'b0);
      drive(2'b00, 2'b00, 1'b1, 1'b0, 6'd0, 1'b0);
      expect_out(304, 2'b00, 2'b01, 2'b01, 6'd1, 1'b0, 2'd0, 6'd2, 1'b0, 1'b0);

      // async reset while station 1 is being served
      drive(2'b10, 2'b10, 1'b0, 1'b0, 6'd0, 1'b0);
      drive(2'b10, 2'b00, 1'b0, 1'b0, 6'd0, 1'b0);
      drive(2'b00, 2'b00, 1'b0, 1'b0, 6'd0, 1'b0);
      expect_out(400, 2'b00, 2'b00, 2'b00, 6'd0, 1'b1, 2'd1, 6'd2, 1'b0, 1'b0);
      #2;
      rstn = 1'b0;
      #1;
      chk("reset_disp_req", 401, 32'(disp_req), 32'd0);
      chk("reset_disp_id",  401, 32'(disp_id),  32'd0);
      chk("reset_stock",    401, 32'(stock),    32'd0);
      chk("reset_sold_out", 401, 32'(sold_out), 32'd1);
      chk("reset_fault",    401, 32'(fault),    32'd0);
      @(negedge clk);
      rstn = 1'b1;
      // credit must restart from 0: three 5c coins needed before a grant
      drive(2'b00, 2'b00, 1'b0, 1'b1, 6'd5, 1'b0);
      expect_out(402, 2'b00, 2'b00, 2'b00, 6'd0, 1'b0, 2'd0, 6'd5, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         drive(2'b10, 2'b00, 1'b0, 1'b0, 6'd0, 1'b0);
         drive(2'b00, 2'b00, 1'b0, 1'b0, 6'd0, 1'b0);
         expect_out(403 + k, 2'b00, 2'b00, 2'b00, 6'd0, 1'b0, 2'd0, 6'd5, 1'b0, 1'b0);
      end
      drive(2'b10, 2'b00, 1'b0, 1'b0, 6'd0, 1'b0);
      drive(2'b00, 2'b00, 1'b0, 1'b0, 6'd0, 1'b0);
      expect_out(405, 2'b00, 2'b00, 2'b00, 6'd0, 1'b1, 2'd1, 6'd5, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/newspaper_dispatch.md
Name: newspaper_dispatch

Overview:
- Multi-station controller for a shared newspaper dispenser mechanism.
- Each of STATIONS coin slots accumulates credit in 5-cent units.
- Stations that reach PRICE are granted the single dispenser in round-robin order over a req/ack handshake.
- The block tracks stock, issues change and refunds, and detects dispenser timeouts.

Parameters:
- STATIONS, 2: number of coin stations sharing the dispenser (2..4).
- PRICE, 3: paper price in 5-cent units (3 = 15 cents).
- STOCK_W, 6: width of the stock counter.
- TIMEOUT, 15: cycles in WAIT without disp_ack before entering FAULT.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- coin_valid  in  STATIONS  per-station coin strobe, one cycle per coin.
- coin  in  STATIONS  coin value: 0 = 5 cents (1 unit), 1 = 10 cents (2 units).
- coin_return  out  STATIONS  one-cycle pulse; the coin just inserted was rejected.
- newspaper  out  STATIONS  one-cycle pulse; paper delivered to that station.
- change_valid  out  STATIONS  one-cycle pulse; change or refund is being paid.
- change_units  out  3*STATIONS  per-station amount in units, valid with change_valid.
- disp_req  out  1  level; dispenser requested.
- disp_id  out  2  station index being served, valid while disp_req.
- disp_ack  in  1  one-cycle pulse from the mechanism; paper dropped.
- stock_load  in  1  load stock_value into the stock counter.
- stock_value  in  STOCK_W  new stock count.
- stock  out  STOCK_W  current stock count.
- sold_out  out  1  high when stock == 0.
- fault  out  1  sticky dispenser timeout flag.
- fault_clr  in  1  clears FAULT and returns the FSM to IDLE.

Behaviour:
Reset (asynchronous, rstn low):
- Credits, pending, stock, last_grant and timer all clear to 0.
- FSM goes to IDLE.
- All pulse outputs, disp_req, disp_id and fault are 0.
- sold_out is 1.
- Reset mid-WAIT drops disp_req immediately; credits are lost.

Credit (per station, 3-bit register):
- A coin is accepted when coin_valid[i] is high, pending[i] is 0, sold_out is 0 and the FSM is not in FAULT. It adds 1 or 2 units at the next clock edge.
- Otherwise coin_return[i] pulses in the following cycle and credit is unchanged.
- pending[i] is registered: set at the same edge where the updated credit is >= PRICE. Maximum credit is PRICE+1.

FSM: IDLE, WAIT, FAULT.
IDLE:
- If stock > 0 and any pending: round-robin pick, starting at last_grant+1.
- Next cycle: disp_req=1, disp_id=winner, state WAIT, timer=0.
- Grant latency is 1 cycle after pending is visible.
- If stock == 0 and stations are pending: refund the lowest-index pending station, one per cycle. change_valid pulses with change_units = its full credit, then its credit and pending clear.
- stock_load is honoured only in IDLE; in other states it is ignored.
WAIT:
- disp_req stays high and disp_id stays stable. The timer increments each cycle.
- On disp_ack:
  - newspaper[id] pulses the next cycle.
  - change_valid[id] pulses in the same cycle, only if credit-PRICE > 0, with change_units = credit-PRICE.
  - credit[id] and pending[id] clear; stock decrements; last_grant = id.
  - disp_req drops; state returns to IDLE.
- If the timer reaches TIMEOUT with no ack: state FAULT.
FAULT:
- disp_req=0, fault=1; all coins are rejected; credits are retained.
- fault_clr moves the FSM to IDLE, clears fault, and re-arbitrates.

Boundary and simultaneous-event rules:
- disp_ack outside WAIT is ignored.
- A coin on the station being served, in the ack cycle, is rejected because pending is still set.
- stock never underflows: a grant requires stock > 0.
- The next arbitration may start the cycle after returning to IDLE.

Decomposition:
- Package newspaper_pkg holds:
  - the FSM state enum (IDLE, WAIT, FAULT);
  - coin encoding constants: COIN_5 = 0, COIN_10 = 1;
  - UNIT_W = 3.
- One sub-module, newspaper_rr_arb (STATIONS requests plus last_grant -> one-hot grant and index).
- Credit logic stays inline in a per-station generate loop.

Test Plan:
- Single paper, exact price: reset, stock_load=5; station0 coins 10c then 5c -> pending0; disp_req=1, disp_id=0 one cycle later. disp_ack -> newspaper[0] pulse, no change_valid, stock=4.
- Overpay and reject: station1 coins 10c, 10c (credit 4 units), then a 5c coin while pending -> coin_return[1] pulse. On ack: change_valid[1] with change_units=1, newspaper[1].
- Round-robin: both stations pending in the same cycle with last_grant=0 -> station1 served first, then station0. Order is 1,0; stock drops by 2.
- Sold out with a pending loser: stock=1, both stations pending -> the first is served. The second gets change_valid with full credit (3), credit cleared; a new coin -> coin_return, sold_out=1.
- Timeout: grant issued, no disp_ack for 15 cycles -> fault=1, disp_req=0, coins rejected. fault_clr -> IDLE and the same station is re-granted with credit intact.
- Async reset mid-WAIT: drop rstn while disp_req=1 -> disp_req=0 immediately, stock=0, sold_out=1, all credits 0.
